sam_enc_p: RTL and testbench
============================

# sam_enc_p

Parametrised serial SAM encoder, next generation of the fixed 16-bit encoder. It receives a configuration over the single-wire `str` input while `mode` is high: length exponent, key `d` and mask `N`. In normal phase it decodes pulse-width-modulated symbols from `str`, encodes each bit as `(b ^ d) | N` and presents complete words on `msgcd` with a one-cycle `valid` pulse. Unlike the previous block, it encodes words back-to-back under one configuration and reports dropped symbols on `err`.

## Interface
- `MAX_LOG`, default 6: maximum length exponent; maximum word length is `MAX_W = 2^MAX_LOG`.
- `NFW`, default 3: width of the serial length-exponent field.
- `MIN_PER`, default 10: minimum legal symbol period (high samples + low samples).
- `MAX_PER`, default 60: maximum legal symbol period and run-length limit.
- `CNT_W`, default 7: width of the run counters. Must satisfy `2^CNT_W > MAX_PER+1`.
- `clk` in 1: clock. All logic runs on the rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `str` in 1: serial config and symbol stream.
- `mode` in 1: 1 selects configuration, 0 selects normal phase.
- `msgcd` out `MAX_W`: last completed encoded word, right-aligned. Bits at index L and above are 0.
- `valid` out 1: one-cycle pulse when `msgcd` is updated.
- `cc` out `MAX_LOG+1`: configured word length L. 0 when unconfigured.
- `err` out 1: one-cycle pulse when a symbol is dropped.

## Operation
- **States:** IDLE, CFG_N, CFG_D, CFG_K, CFG_DONE, NORM.
- **Reset** (asynchronous, any state): go to IDLE. Outputs: `msgcd`=0, `valid`=0, `cc`=0, `err`=0. Clear all counters, `d`, `N` and the shadow word.
- **IDLE**
  - Internal registers are held cleared. `cc`=0.
  - `msgcd` keeps its last value.
  - `mode`=1 -> CFG_N.
- **CFG_N**
  - Sample `NFW` bits of `n`, MSB first, one per cycle.
  - Set L = 2^min(n, MAX_LOG). Values of n above `MAX_LOG` clamp to `MAX_LOG`.
  - -> CFG_D.
- **CFG_D:** sample L bits of `d`, MSB first (index L-1 down to 0). -> CFG_K.
- **CFG_K**
  - Sample L bits of `N`, MSB first.
  - On the last bit: `cc` <= L, then -> CFG_DONE.
- **Abort during configuration:** `mode`=0 in CFG_N, CFG_D or CFG_K -> IDLE. The partial configuration is discarded and `cc`=0. The abort takes effect at the edge where `mode` is sampled 0; that cycle's `str` bit is ignored.
- **CFG_DONE:** `mode`=0 -> NORM. Clear the run counters and the arm flag, and set the word index to L-1.
- **NORM**
  - `mode`=1 -> CFG_N.
  - The new configuration replaces the old one. The partial shadow word is discarded; `msgcd` is held.
- **Symbol decode (NORM)**
  - Rising edge = `str` sampled 1 where the previous sample was 0.
  - Samples before the first rising edge after entering NORM are ignored (arming).
  - After arming, count high samples (`ones`) and low samples (`zeros`). Both counters saturate at `MAX_PER+1`.
  - At each later rising edge, evaluate the preceding symbol, then restart with `ones`=1, `zeros`=0.
  - A symbol is legal when `ones`≥1, `zeros`≥1, `ones+zeros` is in [MIN_PER, MAX_PER], and neither counter is saturated.
  - Legal symbol: b = 1 if `ones`≥`zeros`, else 0.
  - Illegal symbol: `err` pulses, no bit is consumed, and the index is unchanged.
- **Encoding**
  - Shadow bit at index i = `(b ^ d[i]) | N[i]`.
  - The index counts down from L-1.
  - On the bit at index 0: `msgcd` <= shadow word with the final bit merged, `valid` pulses, and the index reloads to L-1. Encoding continues with the same `d`/`N`.

## Timing
- Configuration bits are sampled one per clock. The first `n` bit is sampled on the edge after CFG_N is entered, i.e. one cycle after `mode` is first sampled high.
- `valid`, `msgcd` and `err` update on the same edge that samples the terminating rising edge. They are visible in the following cycle.
- `valid` and `err` are mutually exclusive and never high for more than one cycle.
- Each word needs L+1 rising edges. The last symbol of a word is closed by the next symbol's rising edge, which also starts the next word.
- `mode` rising on the same edge as a terminating rising edge: the state change wins. No `valid` and no `err` are generated.
- Counter arithmetic is unsigned, `CNT_W`+1 bits for the sum. No wrap is permitted.

## Test plan
- **Basic word:** config n=010, d=1010, N=0001. Then send symbols 1,1,0,0, where 1 = 6 high/4 low and 0 = 3 high/7 low, plus a closing rising edge -> `cc`=4, one `valid` pulse, `msgcd`=0x0007, `err`=0.
- **Run too long:** as the basic word, but the second symbol is 70 high/5 low -> one `err` pulse, no bit consumed. A legal replacement symbol yields the same `msgcd`=0x0007.
- **Period too short:** a 4 high/4 low symbol -> `err` pulse. Period 10 (5/5) -> accepted as 1.
- **Config abort:** `mode` drops after 3 `d` bits -> IDLE, `cc`=0. Subsequent NORM-looking traffic yields no `valid`.
- **Back-to-back and clamp:** MAX_LOG=6, n=111, d=0, N=0, 128 alternating legal symbols -> `cc`=64, two `valid` pulses 64 symbols apart, `msgcd`=0xAAAA_AAAA_AAAA_AAAA both times.
- **Reset mid-NORM:** `reset` low during word assembly -> all outputs 0 immediately. After release, no `valid` without a new configuration.

Source files
------------

// File: rtl/sam_enc_p_if.sv
// sam_enc_p_if: serial stream in / encoded word out bundle for sam_enc_p.
//   master (stimulus side): drives str, mode; observes msgcd, valid, cc, err
//   slave  (encoder side) : receives str, mode; drives msgcd, valid, cc, err
//   str   - single-wire configuration and PWM symbol stream
//   mode  - 1 = configuration phase, 0 = normal phase
//   msgcd - last completed encoded word, right-aligned (2^MAX_LOG bits)
//   valid - one-cycle pulse when msgcd updates
//   cc    - configured word length L (0 when unconfigured)
//   err   - one-cycle pulse when a symbol is dropped
interface sam_enc_p_if #(
    parameter int MAX_LOG = 6
);
    logic                      str;
    logic                      mode;
    logic [(1<<MAX_LOG)-1:0]   msgcd;
    logic                      valid;
    logic [MAX_LOG:0]          cc;
    logic                      err;

    modport master (output str, mode, input msgcd, valid, cc, err);
    modport slave  (input str, mode, output msgcd, valid, cc, err);
endinterface

// File: rtl/sam_enc_p.sv
// sam_enc_p: parametrised serial SAM encoder.
// Loads a length exponent n, key d and mask N serially while mode=1, then
// decodes PWM symbols from str, encodes each bit as (b ^ d[i]) | N[i] and
// publishes complete words on msgcd with a one-cycle valid pulse. Dropped
// (illegal) symbols pulse err.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-low
//   bus   - sam_enc_p_if slave (str, mode in; msgcd, valid, cc, err out)
module sam_enc_p #(
    parameter int MAX_LOG = 6,
    parameter int NFW     = 3,
    parameter int MIN_PER = 10,
    parameter int MAX_PER = 60,
    parameter int CNT_W   = 7
) (
    input  logic       clk,
    input  logic       reset,
    sam_enc_p_if.slave bus
);
    localparam int MAX_W = 1 << MAX_LOG;
    localparam int LW    = MAX_LOG + 1;
    // Config bit counter must reach both NFW-1 and L-1.
    localparam int CFW   = (LW > $clog2(NFW) + 1) ? LW : $clog2(NFW) + 1;

    localparam logic [CNT_W-1:0] SAT    = CNT_W'(MAX_PER + 1);
    localparam logic [CNT_W:0]   PER_LO = (CNT_W+1)'(MIN_PER);
    localparam logic [CNT_W:0]   PER_HI = (CNT_W+1)'(MAX_PER);

    typedef enum logic [2:0] {
        IDLE, CFG_N, CFG_D, CFG_K, CFG_DONE, NORM
    } state_t;

    state_t             state_q,  state_d;
    logic               prev_q,   prev_d;
    logic               armed_q,  armed_d;
    logic [CNT_W-1:0]   ones_q,   ones_d;
    logic [CNT_W-1:0]   zeros_q,  zeros_d;
    logic [NFW-1:0]     n_q,      n_d;
    logic [LW-1:0]      l_q,      l_d;
    logic [CFW-1:0]     cfg_cnt_q, cfg_cnt_d;
    logic [MAX_W-1:0]   d_q,      d_d;
    logic [MAX_W-1:0]   nm_q,     nm_d;
    logic [MAX_W-1:0]   shadow_q, shadow_d;
    logic [MAX_LOG-1:0] idx_q,    idx_d;
    logic [MAX_W-1:0]   msgcd_q,  msgcd_d;
    logic               valid_q,  valid_d;
    logic [LW-1:0]      cc_q,     cc_d;
    logic               err_q,    err_d;

    // Symbol evaluation helpers
    logic               rise;
    logic [CNT_W:0]     sum;
    logic               legal;
    logic               sym_bit;
    logic               enc_bit;
    logic [NFW-1:0]     n_shift;
    logic [31:0]        n_ext;
    logic [31:0]        exp_sel;
    logic [LW-1:0]      l_new;
    logic [MAX_LOG-1:0] l_m1;
    logic               cfg_last;

    always_comb begin
        rise    = bus.str & ~prev_q;
        sum     = {1'b0, ones_q} + {1'b0, zeros_q};
        // A saturated counter means the run exceeded MAX_PER: never legal.
        legal   = (ones_q != '0) && (zeros_q != '0) &&
                  (ones_q != SAT) && (zeros_q != SAT) &&
                  (sum >= PER_LO) && (sum <= PER_HI);
        sym_bit = (ones_q >= zeros_q);
        enc_bit = (sym_bit ^ d_q[idx_q]) | nm_q[idx_q];

        n_shift = NFW'({n_q, bus.str});
        n_ext   = 32'(n_shift);
        exp_sel = (n_ext > 32'(MAX_LOG)) ? 32'(MAX_LOG) : n_ext;
        l_new   = LW'(1) << exp_sel;
        l_m1    = MAX_LOG'(l_q - LW'(1));
        cfg_last = (cfg_cnt_q == CFW'(l_q) - CFW'(1));
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = bus.str;
        armed_d   = armed_q;
        ones_d    = ones_q;
        zeros_d   = zeros_q;
        n_d       = n_q;
        l_d       = l_q;
        cfg_cnt_d = cfg_cnt_q;
        d_d       = d_q;
        nm_d      = nm_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        msgcd_d   = msgcd_q;
        valid_d   = 1'b0;
        cc_d      = cc_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // Everything but msgcd is held cleared while idle.
                armed_d   = 1'b0;
                ones_d    = '0;
                zeros_d   = '0;
                n_d       = '0;
                l_d       = '0;
                cfg_cnt_d = '0;
                d_d       = '0;
                nm_d      = '0;
                shadow_d  = '0;
                idx_d     = '0;
                cc_d      = '0;
                if (bus.mode) state_d = CFG_N;
            end
            CFG_N: begin
                if (!bus.mode) begin
                    state_d = IDLE;
                    cc_d    = '0;
                end else begin
                    n_d       = n_shift;
                    cfg_cnt_d = cfg_cnt_q + CFW'(1);
                    if (cfg_cnt_q == CFW'(NFW - 1)) begin
                        l_d       = l_new;
                        cfg_cnt_d = '0;
                        state_d   = CFG_D;
                    end
                end
            end
            CFG_D: begin
                if (!bus.mode) begin
                    state_d = IDLE;
                    cc_d    = '0;
                end else begin
                    // Shifting in MSB first leaves d right-aligned after L bits.
                    d_d       = {d_q[MAX_W-2:0], bus.str};
                    cfg_cnt_d = cfg_cnt_q + CFW'(1);
                    if (cfg_last) begin
                        cfg_cnt_d = '0;
                        state_d   = CFG_K;
                    end
                end
            end
            CFG_K: begin
                if (!bus.mode) begin
                    state_d = IDLE;
                    cc_d    = '0;
                end else begin
                    nm_d      = {nm_q[MAX_W-2:0], bus.str};
                    cfg_cnt_d = cfg_cnt_q + CFW'(1);
                    if (cfg_last) begin
                        cfg_cnt_d = '0;
                        cc_d      = l_q;
                        state_d   = CFG_DONE;
                    end
                end
            end
            CFG_DONE: begin
                if (!bus.mode) begin
                    state_d  = NORM;
                    armed_d  = 1'b0;
                    ones_d   = '0;
                    zeros_d  = '0;
                    shadow_d = '0;
                    idx_d    = l_m1;
                end
            end
            NORM: begin
                if (bus.mode) begin
                    // Reconfiguration wins over any symbol closing this edge.
                    state_d   = CFG_N;
                    armed_d   = 1'b0;
                    ones_d    = '0;
                    zeros_d   = '0;
                    n_d       = '0;
                    cfg_cnt_d = '0;
                    d_d       = '0;
                    nm_d      = '0;
                    shadow_d  = '0;
                end else if (rise) begin
                    if (armed_q) begin
                        if (!legal) begin
                            err_d = 1'b1;
                        end else if (idx_q == '0) begin
                            msgcd_d  = {shadow_q[MAX_W-1:1], enc_bit};
                            valid_d  = 1'b1;
                            shadow_d = '0;
                            idx_d    = l_m1;
                        end else begin
                            shadow_d[idx_q] = enc_bit;
                            idx_d           = idx_q - MAX_LOG'(1);
                        end
                    end
                    // The rising sample is the first high sample of the next symbol.
                    armed_d = 1'b1;
                    ones_d  = CNT_W'(1);
                    zeros_d = '0;
                end else if (armed_q) begin
                    if (bus.str) begin
                        if (ones_q != SAT) ones_d = ones_q + CNT_W'(1);
                    end else begin
                        if (zeros_q != SAT) zeros_d = zeros_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            prev_q    <= 1'b0;
            armed_q   <= 1'b0;
            ones_q    <= '0;
            zeros_q   <= '0;
            n_q       <= '0;
            l_q       <= '0;
            cfg_cnt_q <= '0;
            d_q       <= '0;
            nm_q      <= '0;
            shadow_q  <= '0;
            idx_q     <= '0;
            msgcd_q   <= '0;
            valid_q   <= 1'b0;
            cc_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            armed_q   <= armed_d;
            ones_q    <= ones_d;
            zeros_q   <= zeros_d;
            n_q       <= n_d;
            l_q       <= l_d;
            cfg_cnt_q <= cfg_cnt_d;
            d_q       <= d_d;
            nm_q      <= nm_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            msgcd_q   <= msgcd_d;
            valid_q   <= valid_d;
            cc_q      <= cc_d;
            err_q     <= err_d;
        end
    end

    assign bus.msgcd = msgcd_q;
    assign bus.valid = valid_q;
    assign bus.cc    = cc_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_sam_enc_p.sv
// tb_sam_enc_p: randomized self-checking bench for sam_enc_p.
// A symbol-level reference model (legality by period/run rules, bit list per
// word, word built from d/N) predicts valid, err and msgcd at every
// terminating rising edge.
module tb_sam_enc_p;
    localparam int MAX_LOG = 6;
    localparam int NFW     = 3;
    localparam int MIN_PER = 10;
    localparam int MAX_PER = 60;
    localparam int CNT_W   = 7;

    logic clk = 1'b0;
    logic reset = 1'b0;

    sam_enc_p_if #(.MAX_LOG(MAX_LOG)) bus ();

    sam_enc_p #(
        .MAX_LOG(MAX_LOG), .NFW(NFW), .MIN_PER(MIN_PER),
        .MAX_PER(MAX_PER), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          cfg_ok;
    int          m_l;
    logic [63:0] m_d, m_n, m_msgcd;
    bit          pend;
    int          p_h, p_l;
    bit          bitq[$];
    int          nvalid, nerr;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input logic m, input logic s);
        @(negedge clk);
        bus.mode = m;
        bus.str  = s;
        @(posedge clk);
        #1;
    endtask

    function automatic bit sym_legal(input int h, input int l);
        return h >= 1 && l >= 1 && h <= MAX_PER && l <= MAX_PER &&
               h + l >= MIN_PER && h + l <= MAX_PER;
    endfunction

    // One symbol: h high samples (first one is the rising edge) then l low.
    task automatic send_sym(input int h, input int l);
        logic exp_v, exp_e;
        logic [63:0] w;
        int stray;
        step(1'b0, 1'b1);
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (cfg_ok && pend) begin
            if (sym_legal(p_h, p_l)) begin
                bitq.push_back(p_h >= p_l);
                if (bitq.size() == m_l) begin
                    w = '0;
                    for (int j = 0; j < m_l; j++) begin
                        int i;
                        i = m_l - 1 - j;
                        w[i] = (bitq[j] ^ m_d[i]) | m_n[i];
                    end
                    m_msgcd = w;
                    exp_v   = 1'b1;
                    bitq.delete();
                end
            end else begin
                exp_e = 1'b1;
            end
        end
        if (bus.valid) nvalid++;
        if (bus.err) nerr++;
        chk("valid", 64'(bus.valid), 64'(exp_v));
        chk("err", 64'(bus.err), 64'(exp_e));
        chk("msgcd", bus.msgcd, m_msgcd);
        stray = 0;
        for (int k = 1; k < h; k++) begin
            step(1'b0, 1'b1);
            if (bus.valid || bus.err) stray++;
        end
        for (int k = 0; k < l; k++) begin
            step(1'b0, 1'b0);
            if (bus.valid || bus.err) stray++;
        end
        chk("stray_pulse", 64'(stray), 64'd0);
        if (cfg_ok) begin
            pend = 1'b1;
            p_h  = h;
            p_l  = l;
        end
    endtask

    // Full configuration; s0 is the str value on the mode-rise edge.
    task automatic cfg(input int n, input logic [63:0] d, input logic [63:0] nm, input logic s0);
        int l;
        l = 1 << ((n > MAX_LOG) ? MAX_LOG : n);
        step(1'b1, s0);
        chk("mode_rise_pulse", 64'(bus.valid | bus.err), 64'd0);
        for (int i = NFW - 1; i >= 0; i--) step(1'b1, n[i]);
        for (int i = l - 1; i >= 0; i--) step(1'b1, d[i]);
        for (int i = l - 1; i >= 0; i--) step(1'b1, nm[i]);
        step(1'b0, 1'b0);
        cfg_ok = 1'b1;
        m_l    = l;
        m_d    = d;
        m_n    = nm;
        pend   = 1'b0;
        bitq.delete();
        chk("cc", 64'(bus.cc), 64'(l));
    endtask

    task automatic rand_sym(output int h, output int l);
        int r, p;
        r = $urandom_range(0, 9);
        if (r < 7) begin
            p = $urandom_range(MIN_PER, 30);
            h = $urandom_range(1, p - 1);
            l = p - h;
        end else if (r == 7) begin
            h = $urandom_range(1, 4);
            l = $urandom_range(1, 4);
        end else begin
            h = $urandom_range(1, 70);
            l = $urandom_range(1, 20);
        end
    endtask

    initial begin
        int h, l, v0;
        bus.mode = 1'b0;
        bus.str  = 1'b0;
        cfg_ok = 1'b0; pend = 1'b0; m_msgcd = '0; m_l = 0;
        m_d = '0; m_n = '0; nvalid = 0; nerr = 0;

        #22;
        chk("rst_msgcd", bus.msgcd, 64'd0);
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk("rst_cc", 64'(bus.cc), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic word: 1,1,0,0 + closing edge
        cfg(2, 64'b1010, 64'b0001, 1'b0);
        send_sym(6, 4); send_sym(6, 4); send_sym(3, 7); send_sym(3, 7);
        v0 = nvalid;
        send_sym(6, 4);
        chk("basic_valid_cnt", 64'(nvalid - v0), 64'd1);
        chk("basic_msgcd", bus.msgcd, 64'h7);

        // Run too long: dropped, then replaced
        cfg(2, 64'b1010, 64'b0001, 1'b0);
        v0 = nerr;
        send_sym(6, 4); send_sym(70, 5); send_sym(6, 4);
        send_sym(3, 7); send_sym(3, 7); send_sym(6, 4);
        chk("long_err_cnt", 64'(nerr - v0), 64'd1);
        chk("long_msgcd", bus.msgcd, 64'h7);

        // Period too short, then minimum period accepted
        cfg(2, 64'b1010, 64'b0001, 1'b0);
        v0 = nerr;
        send_sym(4, 4); send_sym(5, 5); send_sym(6, 4);
        send_sym(3, 7); send_sym(3, 7); send_sym(6, 4);
        chk("short_err_cnt", 64'(nerr - v0), 64'd1);
        chk("short_msgcd", bus.msgcd, 64'h7);

        // Abort after 3 d bits
        step(1'b1, 1'b0);
        step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        cfg_ok = 1'b0; pend = 1'b0;
        chk("abort_cc", 64'(bus.cc), 64'd0);
        v0 = nvalid;
        for (int i = 0; i < 8; i++) send_sym(6, 4);
        chk("abort_no_valid", 64'(nvalid - v0), 64'd0);

        // Clamp and back-to-back: n=7 -> L=64
        cfg(7, 64'd0, 64'd0, 1'b0);
        v0 = nvalid;
        for (int i = 0; i < 129; i++) begin
            if (i % 2 == 0) send_sym(6, 4);
            else send_sym(3, 7);
        end
        chk("clamp_valid_cnt", 64'(nvalid - v0), 64'd2);
        chk("clamp_msgcd", bus.msgcd, 64'hAAAA_AAAA_AAAA_AAAA);

        // Randomized configurations and symbol streams
        for (int r = 0; r < 5; r++) begin
            cfg($urandom_range(0, 7), {$urandom, $urandom},
                {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom},
                1'($urandom_range(0, 1)));
            for (int s = 0; s < 40; s++) begin
                rand_sym(h, l);
                send_sym(h, l);
            end
        end

        // Reset mid-NORM
        cfg(2, 64'b0110, 64'b0000, 1'b0);
        send_sym(6, 4); send_sym(3, 7);
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_msgcd", bus.msgcd, 64'd0);
        chk("mid_rst_valid", 64'(bus.valid), 64'd0);
        chk("mid_rst_cc", 64'(bus.cc), 64'd0);
        chk("mid_rst_err", 64'(bus.err), 64'd0);
        cfg_ok = 1'b0; pend = 1'b0; m_msgcd = '0; bitq.delete();
        @(negedge clk);
        reset = 1'b1;
        v0 = nvalid;
        for (int i = 0; i < 8; i++) send_sym(3, 7);
        chk("post_rst_no_valid", 64'(nvalid - v0), 64'd0);
        chk("post_rst_cc", 64'(bus.cc), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Whole-run guard: the stimulus above is far below this bound.
    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
